// File: rtl/regfile_pkg.sv
// Shared widths, requester indices and data types for the register-file
// writeback arbiter.
package regfile_pkg;

    localparam int REG_NUM_WIDTH = 5;
    localparam int REG_WIDTH     = 32;
    localparam int NUM_REQ       = 3;
    localparam int NUM_REGS      = 1 << REG_NUM_WIDTH;

    localparam int REQ_ALU = 0;
    localparam int REQ_LSU = 1;
    localparam int REQ_CSR = 2;

    typedef logic [REG_NUM_WIDTH-1:0] reg_idx_t;
    typedef logic [REG_WIDTH-1:0]     reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer and wraps upward;
// the pointer moves past the winner only when the grant is taken.
module rr_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               taken,
    output logic [NUM_REQ-1:0] grant
);

    localparam int            PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PW:0]   N_W  = (PW+1)'(NUM_REQ);
    localparam logic [PW-1:0] LAST = PW'(NUM_REQ - 1);

    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] win_idx;
    logic [PW:0]   cand_sum;
    logic [PW-1:0] cand;
    logic          found;

    always_comb begin
        grant    = '0;
        win_idx  = ptr_q;
        found    = 1'b0;
        cand_sum = '0;
        cand     = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand_sum = {1'b0, ptr_q} + (PW+1)'(off);
            if (cand_sum >= N_W) begin
                cand_sum = cand_sum - N_W;
            end
            cand = cand_sum[PW-1:0];
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                win_idx     = cand;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (taken) begin
            ptr_d = (win_idx == LAST) ? '0 : win_idx + PW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU/LSU/CSR writeback and
// tracks which destination registers still have a write outstanding.
module regfile_wb_arbiter
    import regfile_pkg::*;
(
    input  logic                             clock,
    input  logic                             reset,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ*REG_NUM_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*REG_WIDTH-1:0]     req_data,
    input  logic                             rsv_en,
    input  reg_idx_t                         rsv_addr,
    input  logic                             rs1En,
    input  reg_idx_t                         rs1Addr,
    input  logic                             rs2En,
    input  reg_idx_t                         rs2Addr,
    output logic                             hazard,
    output logic                             rdEn,
    output reg_idx_t                         rdAddr,
    output reg_data_t                        rdData
);

    // Handshake: requester i transfers in the cycle where req_valid[i] and
    // req_ready[i] are both high; it holds valid/addr/data until then, and
    // ready is never withdrawn while valid is held and the pointer is unchanged.
    logic                handshake;
    reg_idx_t            win_addr;
    reg_data_t           win_data;
    logic                rd_en_q, rd_en_d;
    reg_idx_t            rd_addr_q, rd_addr_d;
    reg_data_t           rd_data_q, rd_data_d;
    logic [NUM_REGS-1:0] pend_q, pend_d;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_arbiter (
        .clock (clock),
        .reset (reset),
        .valid (req_valid),
        .taken (handshake),
        .grant (req_ready)
    );

    assign handshake = |(req_valid & req_ready);

    always_comb begin
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                win_addr = req_addr[i*REG_NUM_WIDTH +: REG_NUM_WIDTH];
                win_data = req_data[i*REG_WIDTH +: REG_WIDTH];
            end
        end
    end

    // x0 writes complete the handshake but never reach the register file.
    always_comb begin
        rd_en_d   = handshake && (win_addr != '0);
        rd_addr_d = handshake ? win_addr : rd_addr_q;
        rd_data_d = handshake ? win_data : rd_data_q;
    end

    // Clear on the commit edge first so a same-edge reservation wins.
    always_comb begin
        pend_d = pend_q;
        if (rd_en_q) begin
            pend_d[rd_addr_q] = 1'b0;
        end
        if (rsv_en && (rsv_addr != '0)) begin
            pend_d[rsv_addr] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            rd_data_q <= '0;
            pend_q    <= '0;
        end else begin
            rd_en_q   <= rd_en_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
            pend_q    <= pend_d;
        end
    end

    // The last term stops a second producer being reserved for a busy register.
    assign hazard = (rs1En && pend_q[rs1Addr]) ||
                    (rs2En && pend_q[rs2Addr]) ||
                    (rsv_en && pend_q[rsv_addr]);

    assign rdEn   = rd_en_q;
    assign rdAddr = rd_addr_q;
    assign rdData = rd_data_q;

    rd_commit_reserved: assert property (
        @(posedge clock) disable iff (!reset) rd_en_q |-> pend_q[rd_addr_q]
    );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus a randomized run
// against a queue/array reference model of arbitration and the scoreboard.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic                             clock;
  logic                             reset;
  logic [NUM_REQ-1:0]               req_valid;
  logic [NUM_REQ-1:0]               req_ready;
  logic [NUM_REQ*REG_NUM_WIDTH-1:0] req_addr;
  logic [NUM_REQ*REG_WIDTH-1:0]     req_data;
  logic                             rsv_en;
  logic [4:0]                       rsv_addr;
  logic                             rs1En;
  logic [4:0]                       rs1Addr;
  logic                             rs2En;
  logic [4:0]                       rs2Addr;
  logic                             hazard;
  logic                             rdEn;
  logic [4:0]                       rdAddr;
  logic [31:0]                      rdData;

  regfile_wb_arbiter dut (
    .clock     (clock),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsv_en    (rsv_en),
    .rsv_addr  (rsv_addr),
    .rs1En     (rs1En),
    .rs1Addr   (rs1Addr),
    .rs2En     (rs2En),
    .rs2Addr   (rs2Addr),
    .hazard    (hazard),
    .rdEn      (rdEn),
    .rdAddr    (rdAddr),
    .rdData    (rdData)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int          m_ptr;
  bit          m_rd_en;
  logic [4:0]  m_rd_addr;
  logic [31:0] m_rd_data;
  bit   [31:0] m_pend;
  logic [36:0] exp_q[$];

  function automatic logic [4:0] addr_of(input int i);
    return req_addr[i*5 +: 5];
  endfunction

  function automatic logic [31:0] data_of(input int i);
    return req_data[i*32 +: 32];
  endfunction

  function automatic logic [2:0] exp_ready();
    for (int k = 0; k < 3; k++) begin
      int i;
      i = (m_ptr + k) % 3;
      if (req_valid[i]) return 3'b001 << i;
    end
    return 3'b000;
  endfunction

  function automatic bit exp_hazard();
    return (rs1En && m_pend[rs1Addr]) || (rs2En && m_pend[rs2Addr]) || (rsv_en && m_pend[rsv_addr]);
  endfunction

  // driver tasks
  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    req_valid[i]       = v;
    req_addr[i*5 +: 5]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic idle_inputs();
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    rsv_en    = 1'b0;
    rsv_addr  = '0;
    rs1En     = 1'b0;
    rs1Addr   = '0;
    rs2En     = 1'b0;
    rs2Addr   = '0;
  endtask

  task automatic model_reset();
    m_ptr     = 0;
    m_rd_en   = 1'b0;
    m_rd_addr = '0;
    m_rd_data = '0;
    m_pend    = '0;
    exp_q.delete();
  endtask

  // one clock edge: model advances from the inputs present before the edge
  task automatic tick();
    logic [2:0]  g;
    int          w;
    logic [4:0]  wa;
    logic [31:0] wd;
    bit   [31:0] np;
    g  = exp_ready();
    w  = -1;
    wa = '0;
    wd = '0;
    for (int i = 0; i < 3; i++) if (g[i]) w = i;
    if (w >= 0) begin
      wa = addr_of(w);
      wd = data_of(w);
    end
    np = m_pend;
    if (m_rd_en) np[m_rd_addr] = 1'b0;
    if (rsv_en && rsv_addr != 0) np[rsv_addr] = 1'b1;
    @(posedge clock);
    if (w >= 0) begin
      m_rd_en   = (wa != 0);
      m_rd_addr = wa;
      m_rd_data = wd;
      m_ptr     = (w + 1) % 3;
      if (wa != 0) exp_q.push_back({wa, wd});
    end else begin
      m_rd_en = 1'b0;
    end
    m_pend = np;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    model_reset();
    set_req(0, 1'b1, 5'd1, $urandom);
    set_req(1, 1'b1, 5'd2, $urandom);
    set_req(2, 1'b1, 5'd3, $urandom);
    repeat (2) @(posedge clock);
    #1;
    n_cmp++; if (rdEn !== 1'b0) begin n_bad++; $display("FAIL reset_rden got=%0b exp=0", rdEn); end
    n_cmp++; if (rdAddr !== 5'd0) begin n_bad++; $display("FAIL reset_rdaddr got=%0d exp=0", rdAddr); end
    n_cmp++; if (rdData !== 32'd0) begin n_bad++; $display("FAIL reset_rddata got=%h exp=0", rdData); end
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL reset_ready got=%b exp=001", req_ready); end
    n_cmp++; if (hazard !== 1'b0) begin n_bad++; $display("FAIL reset_hazard got=%0b exp=0", hazard); end
    reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic [2:0] eg;
      eg = 3'b001 << (k % 3);
      rsv_en   = 1'b1;
      rsv_addr = 5'(k + 1);
      #1;
      n_cmp++; if (req_ready !== eg) begin n_bad++; $display("FAIL rr_grant[%0d] got=%b exp=%b", k, req_ready, eg); end
      tick();
      if (k == 0) set_req(0, 1'b1, 5'd4, $urandom);
      n_cmp++; if (rdEn !== 1'b1) begin n_bad++; $display("FAIL rr_rden[%0d] got=%0b exp=1", k, rdEn); end
      n_cmp++; if (rdAddr !== 5'(k + 1)) begin n_bad++; $display("FAIL rr_rdaddr[%0d] got=%0d exp=%0d", k, rdAddr, k + 1); end
      n_cmp++; if (rdData !== m_rd_data) begin n_bad++; $display("FAIL rr_rddata[%0d] got=%h exp=%h", k, rdData, m_rd_data); end
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_alu_write();
    rsv_en   = 1'b1;
    rsv_addr = 5'd5;
    tick();
    rsv_en = 1'b0;
    set_req(REQ_ALU, 1'b1, 5'd5, 32'hDEADBEEF);
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL alu_ready got=%b exp=001", req_ready); end
    tick();
    set_req(REQ_ALU, 1'b0, 5'd0, 32'd0);
    n_cmp++; if (rdEn !== 1'b1) begin n_bad++; $display("FAIL alu_rden got=%0b exp=1", rdEn); end
    n_cmp++; if (rdAddr !== 5'd5) begin n_bad++; $display("FAIL alu_rdaddr got=%0d exp=5", rdAddr); end
    n_cmp++; if (rdData !== 32'hDEADBEEF) begin n_bad++; $display("FAIL alu_rddata got=%h exp=deadbeef", rdData); end
    tick();
    n_cmp++; if (rdEn !== 1'b0) begin n_bad++; $display("FAIL alu_rden_after got=%0b exp=0", rdEn); end
    n_cmp++; if (rdAddr !== 5'd5) begin n_bad++; $display("FAIL alu_rdaddr_hold got=%0d exp=5", rdAddr); end
    n_cmp++; if (rdData !== 32'hDEADBEEF) begin n_bad++; $display("FAIL alu_rddata_hold got=%h exp=deadbeef", rdData); end
  endtask

  task automatic test_x0_write();
    set_req(REQ_LSU, 1'b1, 5'd0, 32'h1234);
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL x0_ready got=%b exp=010", req_ready); end
    tick();
    set_req(REQ_LSU, 1'b0, 5'd0, 32'd0);
    n_cmp++; if (rdEn !== 1'b0) begin n_bad++; $display("FAIL x0_rden got=%0b exp=0", rdEn); end
    n_cmp++; if (rdAddr !== 5'd0) begin n_bad++; $display("FAIL x0_rdaddr got=%0d exp=0", rdAddr); end
    n_cmp++; if (rdData !== 32'h1234) begin n_bad++; $display("FAIL x0_rddata got=%h exp=1234", rdData); end
    rs1En = 1'b1;
    for (int r = 0; r < 32; r++) begin
      rs1Addr = 5'(r);
      #1;
      n_cmp++; if (hazard !== exp_hazard()) begin n_bad++; $display("FAIL x0_pend[%0d] got=%0b exp=%0b", r, hazard, exp_hazard()); end
    end
    rs1En = 1'b0;
    set_req(0, 1'b1, 5'd0, 32'd0);
    set_req(1, 1'b1, 5'd0, 32'd0);
    set_req(2, 1'b1, 5'd0, 32'd0);
    #1;
    n_cmp++; if (req_ready !== 3'b100) begin n_bad++; $display("FAIL x0_ptr_ready got=%b exp=100", req_ready); end
    idle_inputs();
  endtask

  task automatic test_raw();
    rsv_en   = 1'b1;
    rsv_addr = 5'd7;
    tick();
    rsv_en  = 1'b0;
    rs1En   = 1'b1;
    rs1Addr = 5'd7;
    #1;
    n_cmp++; if (hazard !== 1'b1) begin n_bad++; $display("FAIL raw_hazard0 got=%0b exp=1", hazard); end
    tick();
    n_cmp++; if (hazard !== 1'b1) begin n_bad++; $display("FAIL raw_hazard1 got=%0b exp=1", hazard); end
    set_req(REQ_CSR, 1'b1, 5'd7, $urandom);
    #1;
    n_cmp++; if (req_ready !== 3'b100) begin n_bad++; $display("FAIL raw_ready got=%b exp=100", req_ready); end
    n_cmp++; if (hazard !== 1'b1) begin n_bad++; $display("FAIL raw_hazard_hs got=%0b exp=1", hazard); end
    tick();
    set_req(REQ_CSR, 1'b0, 5'd0, 32'd0);
    #1;
    n_cmp++; if (rdEn !== 1'b1 || rdAddr !== 5'd7) begin n_bad++; $display("FAIL raw_commit got=%0b/%0d exp=1/7", rdEn, rdAddr); end
    n_cmp++; if (hazard !== 1'b1) begin n_bad++; $display("FAIL raw_hazard_commit got=%0b exp=1", hazard); end
    tick();
    n_cmp++; if (hazard !== 1'b0) begin n_bad++; $display("FAIL raw_hazard_clear got=%0b exp=0", hazard); end
    idle_inputs();
  endtask

  task automatic test_same_edge();
    rsv_en   = 1'b1;
    rsv_addr = 5'd9;
    tick();
    rsv_en = 1'b0;
    set_req(REQ_LSU, 1'b1, 5'd9, $urandom);
    #1;
    n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL same_ready got=%b exp=010", req_ready); end
    tick();
    set_req(REQ_LSU, 1'b0, 5'd0, 32'd0);
    rsv_en   = 1'b1;
    rsv_addr = 5'd9;
    #1;
    n_cmp++; if (rdEn !== 1'b1 || rdAddr !== 5'd9) begin n_bad++; $display("FAIL same_commit got=%0b/%0d exp=1/9", rdEn, rdAddr); end
    n_cmp++; if (hazard !== 1'b1) begin n_bad++; $display("FAIL same_hazard_edge got=%0b exp=1", hazard); end
    tick();
    rsv_en = 1'b0;
    rs1En   = 1'b1;
    rs1Addr = 5'd9;
    #1;
    n_cmp++; if (rdEn !== 1'b0) begin n_bad++; $display("FAIL same_rden_after got=%0b exp=0", rdEn); end
    n_cmp++; if (hazard !== 1'b1) begin n_bad++; $display("FAIL same_pend_kept got=%0b exp=1", hazard); end
    rs1En    = 1'b0;
    rsv_en   = 1'b1;
    rsv_addr = 5'd9;
    #1;
    n_cmp++; if (hazard !== 1'b1) begin n_bad++; $display("FAIL same_waw got=%0b exp=1", hazard); end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    rsv_en   = 1'b1;
    rsv_addr = 5'd3;
    tick();
    rsv_en = 1'b0;
    set_req(REQ_ALU, 1'b1, 5'd3, $urandom);
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL mid_ready_alu got=%b exp=001", req_ready); end
    tick();
    set_req(0, 1'b1, 5'd0, 32'd0);
    set_req(1, 1'b1, 5'd0, 32'd0);
    set_req(2, 1'b1, 5'd0, 32'd0);
    rs1En   = 1'b1;
    rs1Addr = 5'd3;
    #1;
    n_cmp++; if (rdEn !== 1'b1 || hazard !== 1'b1) begin n_bad++; $display("FAIL mid_pre got=%0b/%0b exp=1/1", rdEn, hazard); end
    n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL mid_pre_ready got=%b exp=010", req_ready); end
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    n_cmp++; if (rdEn !== 1'b0) begin n_bad++; $display("FAIL mid_rden got=%0b exp=0", rdEn); end
    n_cmp++; if (hazard !== 1'b0) begin n_bad++; $display("FAIL mid_hazard got=%0b exp=0", hazard); end
    n_cmp++; if (rdAddr !== 5'd0 || rdData !== 32'd0) begin n_bad++; $display("FAIL mid_rdbus got=%0d/%h exp=0/0", rdAddr, rdData); end
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL mid_ready got=%b exp=001", req_ready); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_cmp++; if (req_ready !== 3'b001) begin n_bad++; $display("FAIL mid_first_grant got=%b exp=001", req_ready); end
    tick();
    n_cmp++; if (req_ready !== 3'b010) begin n_bad++; $display("FAIL mid_second_grant got=%b exp=010", req_ready); end
    n_cmp++; if (rdEn !== 1'b0) begin n_bad++; $display("FAIL mid_x0_rden got=%0b exp=0", rdEn); end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [4:0] avail_q[$];
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [2:0] g;
      int         w;
      logic [4:0] r;
      logic [36:0] e;
      for (int i = 0; i < 3; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          if (avail_q.size() > 0 && $urandom_range(0, 4) != 0) set_req(i, 1'b1, avail_q.pop_front(), $urandom);
          else set_req(i, 1'b1, 5'd0, $urandom);
        end
      end
      rs1En    = 1'($urandom_range(0, 1));
      rs1Addr  = 5'($urandom_range(0, 31));
      rs2En    = 1'($urandom_range(0, 1));
      rs2Addr  = 5'($urandom_range(0, 31));
      r        = 5'($urandom_range(1, 31));
      rsv_en   = 1'b1;
      rsv_addr = r;
      if (exp_hazard() || $urandom_range(0, 1) == 0) rsv_en = 1'b0;
      #1;
      g = exp_ready();
      w = -1;
      for (int i = 0; i < 3; i++) if (g[i]) w = i;
      n_cmp++; if (req_ready !== g) begin n_bad++; $display("FAIL rand_ready[%0d] got=%b exp=%b", cyc, req_ready, g); end
      n_cmp++; if (hazard !== exp_hazard()) begin n_bad++; $display("FAIL rand_hazard[%0d] got=%0b exp=%0b", cyc, hazard, exp_hazard()); end
      tick();
      if (rsv_en) avail_q.push_back(r);
      if (w >= 0) set_req(w, 1'b0, 5'd0, 32'd0);
      n_cmp++; if (rdEn !== m_rd_en) begin n_bad++; $display("FAIL rand_rden[%0d] got=%0b exp=%0b", cyc, rdEn, m_rd_en); end
      n_cmp++; if (rdAddr !== m_rd_addr || rdData !== m_rd_data) begin n_bad++; $display("FAIL rand_rdbus[%0d] got=%0d/%h exp=%0d/%h", cyc, rdAddr, rdData, m_rd_addr, m_rd_data); end
      if (rdEn === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL rand_sb_empty[%0d] got=%0d/%h exp=none", cyc, rdAddr, rdData);
        end else begin
          e = exp_q.pop_front();
          if ({rdAddr, rdData} !== e) begin n_bad++; $display("FAIL rand_sb[%0d] got=%0d/%h exp=%0d/%h", cyc, rdAddr, rdData, e[36:32], e[31:0]); end
        end
      end
    end
    idle_inputs();
    tick();
    if (rdEn === 1'b1 && exp_q.size() > 0) void'(exp_q.pop_front());
    tick();
    n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rand_sb_leftover got=%0d exp=0", exp_q.size()); end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    model_reset();
    test_reset();
    test_alu_write();
    test_x0_write();
    test_raw();
    test_same_edge();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
